// File: rtl/div_seq_32bit.sv
// Sequential 32-bit restoring divider: one quotient bit per cycle, DONE pulse, held Q/R/DZ.
// Define DIV_SIGNED_EN for signed (DIV) operation with a sign-fix state; default build is unsigned (DIVU).

module Comparator_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        agb,
  output logic        aeb
);
  assign agb = (a > b);
  assign aeb = (a == b);
endmodule

module div_seq_32bit #(
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  output logic          BUSY,
  output logic          DONE,
  output logic [DW-1:0] Q,
  output logic [DW-1:0] R,
  output logic          DZ
);

  if (DW != 32) begin : g_bad_dw
    $error("div_seq_32bit: DW must be 32");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
`ifdef DIV_SIGNED_EN
    S_SFIX,
`endif
    S_ZERO,
    S_DONE
  } state_t;

  state_t        state, next_state;
  logic [4:0]    cnt;
  logic [DW-1:0] rem, qsh, dvs;
  logic [DW:0]   t;
  logic [DW-1:0] rem_next, qsh_next;
  logic [DW-1:0] a_op, b_op;
  logic          agb, aeb, take;

`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r;
  assign a_op = A[DW-1] ? (~A + 1'b1) : A;
  assign b_op = B[DW-1] ? (~B + 1'b1) : B;
`else
  assign a_op = A;
  assign b_op = B;
`endif

  // Bit 32 of the shifted remainder forces a subtract: T >= 2^32 always exceeds the divisor.
  assign t        = {rem, qsh[DW-1]};
  assign take     = t[DW] | agb | aeb;
  assign rem_next = take ? (t[DW-1:0] - dvs) : t[DW-1:0];
  assign qsh_next = {qsh[DW-2:0], take};

  Comparator_32bit u_cmp (
    .a   (t[DW-1:0]),
    .b   (dvs),
    .agb (agb),
    .aeb (aeb)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (START) next_state = (B == '0) ? S_ZERO : S_RUN;
      S_RUN:
        if (cnt == 5'd31) begin
`ifdef DIV_SIGNED_EN
          next_state = S_SFIX;
`else
          next_state = S_DONE;
`endif
        end
`ifdef DIV_SIGNED_EN
      S_SFIX: next_state = S_DONE;
`endif
      S_ZERO: next_state = S_DONE;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY = 1'b0;
    DONE = 1'b0;
    case (state)
      S_RUN:  BUSY = 1'b1;
`ifdef DIV_SIGNED_EN
      S_SFIX: BUSY = 1'b1;
`endif
      S_DONE: DONE = 1'b1;
      default: ;
    endcase
  end

  // On a zero divisor qsh keeps the raw dividend so it can be reported as the remainder.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
      rem <= '0;
      qsh <= '0;
      dvs <= '0;
      Q   <= '0;
      R   <= '0;
      DZ  <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE:
          if (START) begin
            cnt <= '0;
            rem <= '0;
            dvs <= b_op;
            qsh <= (B == '0) ? A : a_op;
`ifdef DIV_SIGNED_EN
            neg_q <= A[DW-1] ^ B[DW-1];
            neg_r <= A[DW-1];
`endif
          end
        S_RUN: begin
          rem <= rem_next;
          qsh <= qsh_next;
          cnt <= cnt + 5'd1;
`ifndef DIV_SIGNED_EN
          if (cnt == 5'd31) begin
            Q  <= qsh_next;
            R  <= rem_next;
            DZ <= 1'b0;
          end
`endif
        end
`ifdef DIV_SIGNED_EN
        S_SFIX: begin
          Q  <= neg_q ? (~qsh + 1'b1) : qsh;
          R  <= neg_r ? (~rem + 1'b1) : rem;
          DZ <= 1'b0;
        end
`endif
        S_ZERO: begin
          Q  <= '1;
          R  <= qsh;
          DZ <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
